// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the commit trace monitor
// Entry layout is {pc, rd, we, data} with a trailing cycle stamp when TRACE_CYCLE_STAMP_EN is defined.
package trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } monitor_state_e;

   localparam int TRACE_PC_W   = 9;
   localparam int TRACE_REG_W  = 5;
   localparam int TRACE_DATA_W = 32;
   localparam int STAMP_W      = 32;
   localparam int DROP_W       = 16;

   localparam bit POLICY_DROP_NEWEST      = 1'b0;
   localparam bit POLICY_OVERWRITE_OLDEST = 1'b1;

   typedef struct packed {
      logic [TRACE_PC_W-1:0]   pc;
      logic [TRACE_REG_W-1:0]  rd;
      logic                    we;
      logic [TRACE_DATA_W-1:0] data;
`ifdef TRACE_CYCLE_STAMP_EN
      logic [STAMP_W-1:0]      cycle;
`endif
   } trace_entry_t;

   function automatic int entry_width(input int pc_w, input int reg_w, input int data_w);
      int w;
      w = pc_w + reg_w + 1 + data_w;
`ifdef TRACE_CYCLE_STAMP_EN
      w = w + STAMP_W;
`endif
      return w;
   endfunction

endpackage

// File: rtl/trace_mw_fifo.sv
// rtl/trace_mw_fifo.sv - multi-write, single-read circular trace buffer
// push_data holds push_num compacted entries in its low slots; full policy selected by OVERWRITE.
module trace_mw_fifo
   import trace_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int ENTRY_W   = 47,
   parameter int DEPTH     = 64,
   parameter bit OVERWRITE = POLICY_DROP_NEWEST
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [LANES*ENTRY_W-1:0]   push_data,
   input  logic [$clog2(DEPTH):0]     push_num,
   input  logic                       pop,
   output logic [ENTRY_W-1:0]         head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic [DROP_W-1:0]          drop_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   head, tail;
   logic [PTR_W-1:0]   wr_idx [LANES];
   logic               pop_ok;
   logic [CNT_W-1:0]   free, n_wr, n_drop, n_adv, count_nxt;
   logic [DROP_W:0]    drop_sum;

   always_comb begin
      pop_ok = pop && (count != '0);
      free   = CNT_W'(DEPTH) - count + CNT_W'(pop_ok);
      n_adv  = CNT_W'(pop_ok);
      n_wr   = push_num;
      n_drop = '0;
      if (push_num > free) begin
         n_drop = push_num - free;
         // Overwriting pushes the head past the clobbered oldest entries.
         if (OVERWRITE == POLICY_OVERWRITE_OLDEST) n_adv = n_adv + n_drop;
         else n_wr = free;
      end
      count_nxt = count + n_wr - n_adv;
      drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(n_drop);
      for (int i = 0; i < LANES; i++)
         wr_idx[i] = PTR_W'((int'(tail) + i) % DEPTH);
      head_data = (count != '0) ? mem[head] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         head     <= PTR_W'((int'(head) + int'(n_adv)) % DEPTH);
         tail     <= PTR_W'((int'(tail) + int'(n_wr)) % DEPTH);
         count    <= count_nxt;
         drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++)
         if (rst && (CNT_W'(i) < n_wr))
            mem[wr_idx[i]] <= push_data[i*ENTRY_W +: ENTRY_W];
   end

endmodule

// File: rtl/commit_trace_monitor.sv
// rtl/commit_trace_monitor.sv - ROB commit trace capture with end-of-program FSM
// TRACE_CYCLE_STAMP_EN adds a free-running cycle stamp per entry and the rd_cycle port.
module commit_trace_monitor
   import trace_pkg::*;
#(
   parameter int COMMIT_WIDTH = 2,
   parameter int PC_W         = TRACE_PC_W,
   parameter int REG_W        = TRACE_REG_W,
   parameter int DATA_W       = TRACE_DATA_W,
   parameter int DEPTH        = 64,
   parameter int TIMEOUT_CYC  = 10000,
   parameter int DRAIN_CYC    = 50,
   parameter bit OVERWRITE    = POLICY_DROP_NEWEST
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [COMMIT_WIDTH-1:0]        commit_valid,
   input  logic [COMMIT_WIDTH*PC_W-1:0]   commit_pc,
   input  logic [COMMIT_WIDTH*REG_W-1:0]  commit_rd,
   input  logic [COMMIT_WIDTH-1:0]        commit_we,
   input  logic [COMMIT_WIDTH*DATA_W-1:0] commit_data,
   input  logic [PC_W-1:0]                fetch_pc,
   input  logic                           rd_ready,
   output logic                           rd_valid,
   output logic [PC_W+REG_W+DATA_W:0]     rd_entry,
   output logic [1:0]                     state,
   output logic                           timed_out,
   output logic [$clog2(DEPTH):0]         count,
   output logic [DROP_W-1:0]              drop_cnt,
   output logic [31:0]                    commit_total
`ifdef TRACE_CYCLE_STAMP_EN
   ,
   output logic [STAMP_W-1:0]             rd_cycle
`endif
);

   localparam int BASE_W  = PC_W + REG_W + 1 + DATA_W;
   localparam int ENTRY_W = entry_width(PC_W, REG_W, DATA_W);
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   monitor_state_e state_q, state_d;
   logic [31:0]    cyc_q, cyc_d;
   logic [PC_W-1:0] prev_pc;
   logic           timed_out_d;
   logic           capture;
   logic           pop;
   logic [CNT_W-1:0] push_num;
   logic [CNT_W-1:0] lane_pos [COMMIT_WIDTH];
   logic [ENTRY_W-1:0] lane_entry [COMMIT_WIDTH];
   logic [COMMIT_WIDTH*ENTRY_W-1:0] push_data;
   logic [ENTRY_W-1:0] head_data;

`ifdef TRACE_CYCLE_STAMP_EN
   logic [STAMP_W-1:0] stamp_q;

   always_ff @(posedge clk) begin
      if (!rst) stamp_q <= '0;
      else      stamp_q <= stamp_q + STAMP_W'(1);
   end
`endif

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q + 32'd1;
      timed_out_d = timed_out;
      case (state_q)
         ST_IDLE: begin
            if (fetch_pc != '0) begin
               state_d = ST_RUN;
               cyc_d   = '0;
            end else if (cyc_q == 32'(TIMEOUT_CYC - 1)) begin
               state_d     = ST_DONE;
               timed_out_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (fetch_pc == '0 && prev_pc != '0) begin
               state_d = ST_DRAIN;
               cyc_d   = '0;
            end else if (cyc_q == 32'(TIMEOUT_CYC - 1)) begin
               state_d     = ST_DONE;
               timed_out_d = 1'b1;
            end
         end
         ST_DRAIN: if (cyc_q == 32'(DRAIN_CYC - 1)) state_d = ST_DONE;
         ST_DONE:  cyc_d = cyc_q;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Compact valid lanes: each valid lane lands in the slot equal to its rank among valid lanes.
   always_comb begin
      capture   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      push_num  = '0;
      push_data = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         lane_pos[i] = push_num;
`ifdef TRACE_CYCLE_STAMP_EN
         lane_entry[i] = {commit_pc[i*PC_W +: PC_W], commit_rd[i*REG_W +: REG_W], commit_we[i],
                          commit_data[i*DATA_W +: DATA_W], stamp_q};
`else
         lane_entry[i] = {commit_pc[i*PC_W +: PC_W], commit_rd[i*REG_W +: REG_W], commit_we[i],
                          commit_data[i*DATA_W +: DATA_W]};
`endif
         if (capture && commit_valid[i]) push_num = push_num + CNT_W'(1);
      end
      for (int j = 0; j < COMMIT_WIDTH; j++)
         for (int i = 0; i < COMMIT_WIDTH; i++)
            if (capture && commit_valid[i] && lane_pos[i] == CNT_W'(j))
               push_data[j*ENTRY_W +: ENTRY_W] = lane_entry[i];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cyc_q        <= '0;
         prev_pc      <= '0;
         timed_out    <= 1'b0;
         commit_total <= '0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         prev_pc      <= fetch_pc;
         timed_out    <= timed_out_d;
         commit_total <= commit_total + 32'(push_num);
      end
   end

   trace_mw_fifo #(
      .LANES     (COMMIT_WIDTH),
      .ENTRY_W   (ENTRY_W),
      .DEPTH     (DEPTH),
      .OVERWRITE (OVERWRITE)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_data (push_data),
      .push_num  (push_num),
      .pop       (pop),
      .head_data (head_data),
      .count     (count),
      .drop_cnt  (drop_cnt)
   );

   assign rd_valid = (count != '0);
   assign pop      = rd_valid && rd_ready;
   assign rd_entry = head_data[ENTRY_W-1 -: BASE_W];
   assign state    = state_q;
`ifdef TRACE_CYCLE_STAMP_EN
   assign rd_cycle = head_data[STAMP_W-1:0];
`endif

endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb/tb_commit_trace_monitor.sv - self-checking bench for commit_trace_monitor
module tb_commit_trace_monitor;
   import trace_pkg::*;

   localparam int EW = 47;

   typedef struct {
      logic [1:0]  v;
      logic [8:0]  p0, p1;
      logic [4:0]  r0, r1;
      logic [1:0]  we;
      logic [31:0] d0, d1;
      int          exp_n;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, rst_ow;
   logic [1:0]  commit_valid, commit_we;
   logic [17:0] commit_pc;
   logic [9:0]  commit_rd;
   logic [63:0] commit_data;
   logic [8:0]  fetch_pc;
   logic        rdy_m, rdy_o0, rdy_o1;

   logic m_valid, t_valid, o0_valid, o1_valid;
   logic [EW-1:0] m_entry, t_entry, o0_entry, o1_entry;
   logic [1:0] m_state, t_state, o0_state, o1_state;
   logic m_to, t_to, o0_to, o1_to;
   logic [6:0] m_count, t_count;
   logic [2:0] o0_count, o1_count;
   logic [15:0] m_drop, t_drop, o0_drop, o1_drop;
   logic [31:0] m_total, t_total, o0_total, o1_total;

   int errors = 0;
   int checks = 0;
   int exp_total = 0;
   int drained;
   logic [EW-1:0] sb [$];
   vec_t tbl [6];

   always #5 clk = ~clk;

   commit_trace_monitor u_main (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_rd(commit_rd), .commit_we(commit_we), .commit_data(commit_data),
      .fetch_pc(fetch_pc), .rd_ready(rdy_m), .rd_valid(m_valid), .rd_entry(m_entry),
      .state(m_state), .timed_out(m_to), .count(m_count), .drop_cnt(m_drop),
      .commit_total(m_total));

   commit_trace_monitor #(.TIMEOUT_CYC(20)) u_to (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_rd(commit_rd), .commit_we(commit_we), .commit_data(commit_data),
      .fetch_pc(fetch_pc), .rd_ready(1'b0), .rd_valid(t_valid), .rd_entry(t_entry),
      .state(t_state), .timed_out(t_to), .count(t_count), .drop_cnt(t_drop),
      .commit_total(t_total));

   commit_trace_monitor #(.DEPTH(4), .OVERWRITE(1'b0)) u_ow0 (
      .clk(clk), .rst(rst_ow), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_rd(commit_rd), .commit_we(commit_we), .commit_data(commit_data),
      .fetch_pc(fetch_pc), .rd_ready(rdy_o0), .rd_valid(o0_valid), .rd_entry(o0_entry),
      .state(o0_state), .timed_out(o0_to), .count(o0_count), .drop_cnt(o0_drop),
      .commit_total(o0_total));

   commit_trace_monitor #(.DEPTH(4), .OVERWRITE(1'b1)) u_ow1 (
      .clk(clk), .rst(rst_ow), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_rd(commit_rd), .commit_we(commit_we), .commit_data(commit_data),
      .fetch_pc(fetch_pc), .rd_ready(rdy_o1), .rd_valid(o1_valid), .rd_entry(o1_entry),
      .state(o1_state), .timed_out(o1_to), .count(o1_count), .drop_cnt(o1_drop),
      .commit_total(o1_total));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [8:0] pc, input logic [4:0] rd,
                                        input logic we, input logic [31:0] d);
      return {pc, rd, we, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_step();
      fetch_pc = fetch_pc + 9'd4;
      step();
   endtask

   task automatic drive(input vec_t r);
      commit_valid = r.v;
      commit_pc    = {r.p1, r.p0};
      commit_rd    = {r.r1, r.r0};
      commit_we    = r.we;
      commit_data  = {r.d1, r.d0};
      if (r.v[0]) sb.push_back(mk(r.p0, r.r0, r.we[0], r.d0));
      if (r.v[1]) sb.push_back(mk(r.p1, r.r1, r.we[1], r.d1));
   endtask

   // Three double-commit cycles c1..c6 = 0x100..0x114; optional pop on the last cycle.
   task automatic ow_run(input bit pop_last);
      vec_t r;
      for (int c = 0; c < 3; c++) begin
         r = '{2'b11, 9'h100 + 9'(8*c), 9'h104 + 9'(8*c), 5'(2*c), 5'(2*c+1), 2'b01,
               32'hA000_0000 + 32'(c), 32'hB000_0000 + 32'(c), 2};
         drive(r);
         exp_total += 2;
         if (pop_last && c == 2) begin
            rdy_o0 = 1'b1;
            rdy_o1 = 1'b1;
         end
         run_step();
         commit_valid = '0;
         rdy_o0 = 1'b0;
         rdy_o1 = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{2'b11, 9'h010, 9'h014, 5'd1,  5'd2, 2'b11, 32'h1111_1111, 32'h2222_2222, 2};
      tbl[1] = '{2'b00, 9'h0F0, 9'h0F4, 5'd9,  5'd9, 2'b11, 32'h9999_9999, 32'h9999_9999, 0};
      tbl[2] = '{2'b10, 9'h0EE, 9'h018, 5'd0,  5'd3, 2'b00, 32'h5555_5555, 32'hABCD_0000, 1};
      tbl[3] = '{2'b01, 9'h01C, 9'h0EC, 5'd31, 5'd8, 2'b01, 32'hFFFF_FFFF, 32'h7777_7777, 1};
      tbl[4] = '{2'b11, 9'h020, 9'h024, 5'd0,  5'd7, 2'b10, 32'h0000_0000, 32'h1234_5678, 2};
      tbl[5] = '{2'b11, 9'h1FC, 9'h000, 5'd4,  5'd6, 2'b11, 32'hCAFE_F00D, 32'h0BAD_CAFE, 2};

      rst = 1'b0; rst_ow = 1'b0;
      commit_valid = '0; commit_we = '0; commit_pc = '0; commit_rd = '0; commit_data = '0;
      fetch_pc = '0; rdy_m = 1'b0; rdy_o0 = 1'b0; rdy_o1 = 1'b0;
      step();
      step();
      check("rst_state", m_state, 0);
      check("rst_count", m_count, 0);
      check("rst_valid", m_valid, 0);
      check("rst_entry", m_entry, 0);
      check("rst_drop", m_drop, 0);
      check("rst_total", m_total, 0);
      check("rst_timed_out", m_to, 0);

      rst = 1'b1;
      repeat (22) step();
      check("idle_to_flag", t_to, 1);
      check("idle_to_state", t_state, 3);
      check("idle_to_count", t_count, 0);
      check("main_still_idle", m_state, 0);

      fetch_pc = 9'h004;
      step();
      check("enter_run", m_state, 1);

      fetch_pc = 9'h008;
      drive('{2'b01, 9'h004, 9'h000, 5'd5, 5'd0, 2'b01, 32'hDEAD_BEEF, 32'h0, 1});
      exp_total = 1;
      step();
      commit_valid = '0;
      check("first_entry", m_entry, mk(9'h004, 5'd5, 1'b1, 32'hDEAD_BEEF));
      check("first_count", m_count, 1);

      for (int k = 0; k < 6; k++) begin
         drive(tbl[k]);
         exp_total += tbl[k].exp_n;
         run_step();
         commit_valid = '0;
         check($sformatf("tbl%0d_total", k), m_total, 32'(exp_total));
         check($sformatf("tbl%0d_count", k), m_count, 7'(sb.size()));
      end

      rst_ow = 1'b1;
      run_step();
      check("ow_enter_run", o0_state, 1);
      ow_run(1'b0);
      check("ow0_count", o0_count, 4);
      check("ow0_drop", o0_drop, 2);
      check("ow0_head", o0_entry[EW-1 -: 9], 9'h100);
      check("ow1_count", o1_count, 4);
      check("ow1_drop", o1_drop, 2);
      check("ow1_head", o1_entry[EW-1 -: 9], 9'h108);

      rst_ow = 1'b0;
      run_step();
      rst_ow = 1'b1;
      run_step();
      ow_run(1'b1);
      check("ow0p_count", o0_count, 4);
      check("ow0p_drop", o0_drop, 1);
      check("ow0p_head", o0_entry[EW-1 -: 9], 9'h104);
      check("ow1p_count", o1_count, 4);
      check("ow1p_drop", o1_drop, 1);
      check("ow1p_head", o1_entry[EW-1 -: 9], 9'h108);

      rdy_o0 = 1'b1;
      run_step();
      rdy_o0 = 1'b0;
      check("ow0_after_pop", o0_count, 3);

      for (int g = 0; g < 200 && fetch_pc != 9'h1FC; g++) run_step();
      fetch_pc = 9'h000;
      step();
      check("wrap_drain", m_state, 2);
      check("ow0_drain", o0_state, 2);
      check("ow0_drain_count", o0_count, 3);

      rst_ow = 1'b0;
      step();
      drained = 1;
      check("ow0_rst_state", o0_state, 0);
      check("ow0_rst_count", o0_count, 0);
      check("ow0_rst_valid", o0_valid, 0);
      rst_ow = 1'b1;

      while (m_state != 2'd3 && drained < 100) begin
         step();
         drained++;
      end
      check("drain_len", drained, 50);
      check("main_timed_out", m_to, 0);
      check("main_drop", m_drop, 0);
      check("main_total", m_total, 32'(exp_total));

      rdy_m = 1'b1;
      for (int g = 0; g < 100 && sb.size() > 0; g++) begin
         check($sformatf("pop%0d_valid", g), m_valid, 1);
         check($sformatf("pop%0d_entry", g), m_entry, sb.pop_front());
         step();
      end
      rdy_m = 1'b0;
      check("end_count", m_count, 0);
      check("end_valid", m_valid, 0);
      check("end_entry", m_entry, 0);
      check("done_holds", m_state, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
